// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// Included by imem_loader and byte_packer; CHECK is only reachable with IMEM_LOADER_CHECKSUM_EN.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        CHECK,
        DONE,
        ERR
    } state_t;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

    // A load is in progress in these states; start is ignored while here.
    function automatic logic is_busy(input state_t s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) ||
               (s == WRITE)  || (s == CHECK);
    endfunction

    function automatic logic takes_bytes(input state_t s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CHECK);
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Four-lane little-endian byte packer: lane 0 is bits [7:0] of the assembled word.
module byte_packer
    import loader_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [LANE_W-1:0] i_lane,
    input  logic [7:0]        i_byte,
    output logic [31:0]       o_word
);

    logic [BYTES_PER_WORD-1:0][7:0] r_lanes;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_lanes <= '0;
        end else if (i_load) begin
            r_lanes[i_lane] <= i_byte;
        end
    end

    assign o_word = r_lanes;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> 32-bit imem words, holding the core in reset until done.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [31:0]           imem_wdata,
    output logic                  core_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned MAX_WORDS = 2 ** ADDR_WIDTH;
    // One extra bit so a full-capacity count (MAX_WORDS) is representable.
    localparam int CNT_W = ADDR_WIDTH + 1;

    state_t                r_state;
    state_t                w_state_next;
    logic [7:0]            r_len_lo;
    logic [15:0]           r_len;
    logic [LANE_W-1:0]     r_byte_cnt;
    logic [CNT_W-1:0]      r_word_cnt;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic                  r_ready;
    logic                  r_we;
    logic                  r_core_reset;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;

    logic                  w_xfer;
    logic                  w_start_ok;
    logic [15:0]           w_len;
    logic                  w_len_bad;
    logic                  w_last_byte;
    logic [CNT_W-1:0]      w_word_cnt_inc;
    logic                  w_last_word;
    logic                  w_pack_load;
    logic [31:0]           w_packed;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            r_csum;
`endif

    assign w_xfer         = byte_valid & r_ready;
    assign w_start_ok     = start & ~is_busy(r_state);
    assign w_len          = {byte_data, r_len_lo};
    assign w_len_bad      = (w_len == 16'd0) || (32'(w_len) > MAX_WORDS);
    assign w_last_byte    = (r_byte_cnt == LANE_W'(BYTES_PER_WORD - 1));
    assign w_word_cnt_inc = r_word_cnt + CNT_W'(1);
    assign w_last_word    = (16'(w_word_cnt_inc) == r_len);
    assign w_pack_load    = (r_state == DATA) && w_xfer;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE, ERR: begin
                if (start) w_state_next = LEN_LO;
            end
            LEN_LO: begin
                if (w_xfer) w_state_next = LEN_HI;
            end
            LEN_HI: begin
                if (w_xfer) w_state_next = w_len_bad ? ERR : DATA;
            end
            DATA: begin
                if (w_xfer && w_last_byte) w_state_next = WRITE;
            end
            WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                w_state_next = w_last_word ? CHECK : DATA;
`else
                w_state_next = w_last_word ? DONE : DATA;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (w_xfer) w_state_next = (byte_data == r_csum) ? DONE : ERR;
            end
`endif
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each one is a clean state decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_ready      <= 1'b0;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_core_reset <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_len_lo     <= '0;
            r_len        <= '0;
            r_byte_cnt   <= '0;
            r_word_cnt   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            r_state      <= w_state_next;
            r_ready      <= takes_bytes(w_state_next);
            r_we         <= (w_state_next == WRITE);
            r_core_reset <= (w_state_next != DONE);
            r_busy       <= is_busy(w_state_next);
            r_done       <= (w_state_next == DONE);
            r_error      <= (w_state_next == ERR);

            case (r_state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        r_byte_cnt <= '0;
                        r_word_cnt <= '0;
                        r_waddr    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum     <= '0;
`endif
                    end
                end
                LEN_LO: begin
                    if (w_xfer) r_len_lo <= byte_data;
                end
                LEN_HI: begin
                    if (w_xfer) r_len <= w_len;
                end
                DATA: begin
                    if (w_xfer) begin
                        r_byte_cnt <= r_byte_cnt + LANE_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum     <= r_csum ^ byte_data;
`endif
                        if (w_last_byte) r_waddr <= r_word_cnt[ADDR_WIDTH-1:0];
                    end
                end
                WRITE: begin
                    r_word_cnt <= w_word_cnt_inc;
                end
                default: ;
            endcase
        end
    end

    byte_packer u_packer (
        .i_clk   (clk),
        .i_reset (reset),
        .i_clear (w_start_ok),
        .i_load  (w_pack_load),
        .i_lane  (r_byte_cnt),
        .i_byte  (byte_data),
        .o_word  (w_packed)
    );

    assign byte_ready = r_ready;
    assign imem_we    = r_we;
    assign imem_waddr = r_waddr;
    assign imem_wdata = w_packed;
    assign core_reset = r_core_reset;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: hand-built byte streams, write log captured on the falling edge.
// Also exercises the checksum path when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

    localparam int AW = 6;

    logic          clk;
    logic          reset;
    logic          start;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          core_reset;
    logic          busy;
    logic          done;
    logic          error;

    int            n_checks;
    int            n_errors;
    int            we_rdy_bad;
    logic [7:0]    tb_csum;
    logic [31:0]   wr_addr[$];
    logic [31:0]   wr_data[$];
    logic [31:0]   exp_w[$];

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(32'(imem_waddr));
            wr_data.push_back(imem_wdata);
            if (byte_ready) we_rdy_bad++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called and returns on a falling edge; returns one falling edge after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input bit jit);
        int idle;
        int t;
        idle = jit ? int'($urandom_range(0, 2)) : 0;
        byte_valid = 1'b0;
        for (int k = 0; k < idle; k++) begin
            byte_data = 8'($urandom);
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        t = 0;
        while (!byte_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!byte_ready) chk("ready_timeout", 32'(byte_ready), 32'd1);
        else @(negedge clk);
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_len(input logic [15:0] n, input bit jit);
        tb_csum = 8'h00;
        send_byte(n[7:0], jit);
        send_byte(n[15:8], jit);
    endtask

    task automatic send_word(input logic [31:0] w, input bit jit);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], jit);
            tb_csum = tb_csum ^ w[8*i +: 8];
        end
    endtask

    // Ends on a falling edge with the loader in DONE for a good image.
    task automatic finish_image();
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(tb_csum, 1'b0);
`else
        @(negedge clk);
`endif
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_byte_ready"}, 32'(byte_ready), 32'd0);
        chk({pfx, "_imem_we"},    32'(imem_we),    32'd0);
        chk({pfx, "_waddr"},      32'(imem_waddr), 32'd0);
        chk({pfx, "_wdata"},      imem_wdata,      32'd0);
        chk({pfx, "_core_reset"}, 32'(core_reset), 32'd1);
        chk({pfx, "_busy"},       32'(busy),       32'd0);
        chk({pfx, "_done"},       32'(done),       32'd0);
        chk({pfx, "_error"},      32'(error),      32'd0);
    endtask

    task automatic chk_log(input string pfx);
        chk({pfx, "_nwrites"}, 32'(wr_addr.size()), 32'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < wr_addr.size(); i++) begin
            chk($sformatf("%s_addr%0d", pfx, i), wr_addr[i], 32'(i));
            chk($sformatf("%s_data%0d", pfx, i), wr_data[i], exp_w[i]);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        exp_w.delete();
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        we_rdy_bad = 0;
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        tb_csum    = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        reset = 1'b0;
        @(negedge clk);

        // Single word 0x00A00513; write appears the cycle after the 4th byte.
        clear_log();
        pulse_start();
        chk("t1_busy", 32'(busy), 32'd1);
        send_len(16'd1, 1'b0);
        send_word(32'h00A00513, 1'b0);
        chk("t1_we_latency", 32'(imem_we), 32'd1);
        chk("t1_waddr", 32'(imem_waddr), 32'd0);
        chk("t1_wdata", imem_wdata, 32'h00A00513);
        finish_image();
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_core_reset", 32'(core_reset), 32'd0);
        chk("t1_nwrites", 32'(wr_addr.size()), 32'd1);

        // Restart from DONE, then N=3 with random valid gaps and a start pulse mid-word.
        clear_log();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t2_core_reset_on_restart", 32'(core_reset), 32'd1);
        chk("t2_done_cleared", 32'(done), 32'd0);
        chk("t2_busy", 32'(busy), 32'd1);
        exp_w.push_back(32'h11223344);
        exp_w.push_back(32'hDEADBEEF);
        exp_w.push_back(32'h00000093);
        send_len(16'd3, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h33, 1'b1);
        tb_csum = 8'h44 ^ 8'h33;
        pulse_start();
        chk("t2_start_ignored_busy", 32'(busy), 32'd1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h11, 1'b1);
        tb_csum = tb_csum ^ 8'h22 ^ 8'h11;
        send_word(32'hDEADBEEF, 1'b1);
        send_word(32'h00000093, 1'b1);
        finish_image();
        chk("t2_done", 32'(done), 32'd1);
        chk_log("t2");
        chk("t2_ready_in_write", 32'(we_rdy_bad), 32'd0);

        // Zero length goes straight to ERR.
        clear_log();
        pulse_start();
        send_len(16'h0000, 1'b0);
        chk("t3_error", 32'(error), 32'd1);
        chk("t3_core_reset", 32'(core_reset), 32'd1);
        chk("t3_byte_ready", 32'(byte_ready), 32'd0);
        chk("t3_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t3_nwrites", 32'(wr_addr.size()), 32'd0);

        // Length 65 exceeds 64-word capacity.
        pulse_start();
        chk("t4_left_err", 32'(error), 32'd0);
        send_len(16'h0041, 1'b0);
        chk("t4_error", 32'(error), 32'd1);
        chk("t4_done", 32'(done), 32'd0);

        // Full capacity: 64 words, last address 63.
        clear_log();
        pulse_start();
        send_len(16'h0040, 1'b0);
        for (int i = 0; i < 64; i++) begin
            exp_w.push_back({8'(i), 8'(~i), 8'hA5, 8'(i * 3)});
            send_word({8'(i), 8'(~i), 8'hA5, 8'(i * 3)}, 1'b0);
        end
        finish_image();
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_last_waddr", 32'(imem_waddr), 32'd63);
        chk_log("t5");

        // Reset in the middle of a three-word load, then a clean reload.
        clear_log();
        pulse_start();
        send_len(16'd3, 1'b0);
        send_word(32'h01020304, 1'b0);
        send_word(32'h05060708, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        chk("t6_waddr_before_reset", 32'(imem_waddr), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("t6");
        reset = 1'b0;
        @(negedge clk);
        clear_log();
        exp_w.push_back(32'hCAFEF00D);
        pulse_start();
        send_len(16'd1, 1'b0);
        send_word(32'hCAFEF00D, 1'b0);
        finish_image();
        chk("t6_reload_done", 32'(done), 32'd1);
        chk_log("t6_reload");

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Explicit checksum bytes: 0xB6 matches 13^05^A0^00, 0x00 does not.
        clear_log();
        pulse_start();
        send_len(16'd1, 1'b0);
        send_word(32'h00A00513, 1'b0);
        chk("t7_busy_check", 32'(busy), 32'd1);
        send_byte(8'hB6, 1'b0);
        chk("t7_good_done", 32'(done), 32'd1);
        chk("t7_good_core_reset", 32'(core_reset), 32'd0);
        clear_log();
        pulse_start();
        send_len(16'd1, 1'b0);
        send_word(32'h00A00513, 1'b0);
        send_byte(8'h00, 1'b0);
        chk("t7_bad_error", 32'(error), 32'd1);
        chk("t7_bad_done", 32'(done), 32'd0);
        chk("t7_bad_word_kept", 32'(wr_addr.size()), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
